// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding control: forward-select codes,
// select width and the bit layout of one in-flight destination slot.
package id_hazard_ctrl_pkg;

  localparam int FWD_CTRL_W = 3;

  typedef enum logic [FWD_CTRL_W-1:0] {
    FWD_SRC_GR      = 3'd0,
    FWD_SRC_EX      = 3'd1,
    FWD_SRC_MM1     = 3'd2,
    FWD_SRC_MM2_REG = 3'd3,
    FWD_SRC_MM2_MEM = 3'd4,
    FWD_SRC_WB      = 3'd5
  } fwd_src_e;

  // Slot = {vld, dest[REG_AW-1:0], late}; late sits at bit 0, vld on top.
  localparam int SLOT_LATE     = 0;
  localparam int SLOT_DEST_LSB = 1;

  function automatic int slot_w(input int reg_aw);
    return reg_aw + 2;
  endfunction

  function automatic int slot_vld(input int reg_aw);
    return reg_aw + 1;
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_fwd_sel.sv
// Per-operand priority encoder: youngest matching in-flight slot decides the forward
// source, or requests a stall when that slot's result is not produced yet.
module id_hazard_ctrl_fwd_sel
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0]     src_i,
  input  logic                  use_i,
  input  logic [REG_AW+1:0]     slot_ex_i,
  input  logic [REG_AW+1:0]     slot_mm1_i,
  input  logic [REG_AW+1:0]     slot_mm2_i,
  input  logic [REG_AW+1:0]     slot_wb_i,
  output logic                  stall_req_o,
  output logic [FWD_CTRL_W-1:0] fwd_ctrl_o
);

  localparam int VLD = slot_vld(REG_AW);

  logic hit_ex, hit_mm1, hit_mm2, hit_wb;
  logic src_live;

  assign src_live = use_i & (src_i != '0);

  assign hit_ex  = src_live & slot_ex_i[VLD]
                 & (slot_ex_i[SLOT_DEST_LSB +: REG_AW] == src_i);
  assign hit_mm1 = src_live & slot_mm1_i[VLD]
                 & (slot_mm1_i[SLOT_DEST_LSB +: REG_AW] == src_i);
  assign hit_mm2 = src_live & slot_mm2_i[VLD]
                 & (slot_mm2_i[SLOT_DEST_LSB +: REG_AW] == src_i);
  assign hit_wb  = src_live & slot_wb_i[VLD]
                 & (slot_wb_i[SLOT_DEST_LSB +: REG_AW] == src_i);

  always_comb begin
    stall_req_o = 1'b0;
    fwd_ctrl_o  = FWD_SRC_GR;
    if (hit_ex) begin
      if (slot_ex_i[SLOT_LATE]) stall_req_o = 1'b1;
      else                      fwd_ctrl_o  = FWD_SRC_EX;
    end else if (hit_mm1) begin
      if (slot_mm1_i[SLOT_LATE]) stall_req_o = 1'b1;
      else                       fwd_ctrl_o  = FWD_SRC_MM1;
    end else if (hit_mm2) begin
      fwd_ctrl_o = slot_mm2_i[SLOT_LATE] ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
    end else if (hit_wb) begin
      fwd_ctrl_o = FWD_SRC_WB;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/forwarding control: shadow pipeline of destination tags (EX..WB).
// Optional stall counter enabled by defining HAZ_PERF_CNT_EN.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pipe_en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rj,
  input  logic [REG_AW-1:0]     id_rk,
  input  logic                  id_use_rj,
  input  logic                  id_use_rk,
  input  logic [REG_AW-1:0]     id_dest,
  input  logic                  id_wen,
  input  logic                  id_res_late,
  output logic [FWD_CTRL_W-1:0] fwd_ctrl_j,
  output logic [FWD_CTRL_W-1:0] fwd_ctrl_k,
  output logic                  id_stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int SW = slot_w(REG_AW);

  logic [SW-1:0] slot_ex_q,  slot_ex_d;
  logic [SW-1:0] slot_mm1_q, slot_mm1_d;
  logic [SW-1:0] slot_mm2_q, slot_mm2_d;
  logic [SW-1:0] slot_wb_q,  slot_wb_d;
  logic [SW-1:0] id_slot;
  logic          stall_j, stall_k;

  id_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_sel_j (
    .src_i      (id_rj),
    .use_i      (id_use_rj),
    .slot_ex_i  (slot_ex_q),
    .slot_mm1_i (slot_mm1_q),
    .slot_mm2_i (slot_mm2_q),
    .slot_wb_i  (slot_wb_q),
    .stall_req_o(stall_j),
    .fwd_ctrl_o (fwd_ctrl_j)
  );

  id_hazard_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_sel_k (
    .src_i      (id_rk),
    .use_i      (id_use_rk),
    .slot_ex_i  (slot_ex_q),
    .slot_mm1_i (slot_mm1_q),
    .slot_mm2_i (slot_mm2_q),
    .slot_wb_i  (slot_wb_q),
    .stall_req_o(stall_k),
    .fwd_ctrl_o (fwd_ctrl_k)
  );

  assign id_stall = id_valid & (stall_j | stall_k);

  // r0 writes and non-writers become empty slots so they can never match.
  always_comb begin
    id_slot = '0;
    if (id_valid && !id_stall && id_wen && (id_dest != '0))
      id_slot = {1'b1, id_dest, id_res_late};
  end

  always_comb begin
    slot_ex_d  = slot_ex_q;
    slot_mm1_d = slot_mm1_q;
    slot_mm2_d = slot_mm2_q;
    slot_wb_d  = slot_wb_q;
    if (flush) begin
      slot_ex_d  = '0;
      slot_mm1_d = '0;
      slot_mm2_d = '0;
      slot_wb_d  = '0;
    end else if (pipe_en) begin
      slot_wb_d  = slot_mm2_q;
      slot_mm2_d = slot_mm1_q;
      slot_mm1_d = slot_ex_q;
      slot_ex_d  = id_slot;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_ex_q  <= '0;
      slot_mm1_q <= '0;
      slot_mm2_q <= '0;
      slot_wb_q  <= '0;
    end else begin
      slot_ex_q  <= slot_ex_d;
      slot_mm1_q <= slot_mm1_d;
      slot_mm2_q <= slot_mm2_d;
      slot_wb_q  <= slot_wb_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only stalls that actually cost an advance are counted; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (id_stall && pipe_en) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus randomized traffic against a
// list-based model of the in-flight destination tags.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              pipe_en, flush, id_valid;
  logic [REG_AW-1:0] id_rj, id_rk, id_dest;
  logic              id_use_rj, id_use_rk, id_wen, id_res_late;
  logic [2:0]        fwd_ctrl_j, fwd_ctrl_k;
  logic              id_stall;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_en    (pipe_en),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rj      (id_rj),
    .id_rk      (id_rk),
    .id_use_rj  (id_use_rj),
    .id_use_rk  (id_use_rk),
    .id_dest    (id_dest),
    .id_wen     (id_wen),
    .id_res_late(id_res_late),
    .fwd_ctrl_j (fwd_ctrl_j),
    .fwd_ctrl_k (fwd_ctrl_k),
    .id_stall   (id_stall),
    .stall_cnt  (stall_cnt)
  );

  // Model: in-flight list, index 0 = youngest (EX) .. 3 = oldest (WB).
  typedef struct {
    bit vld;
    int dest;
    bit late;
  } ent_t;

  ent_t        mdl[4];
  int unsigned exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) mdl[i] = '{vld: 1'b0, dest: 0, late: 1'b0};
  endfunction

  function automatic void model_sel(input int s, input bit use_s, output int code, output bit stl);
    code = FWD_SRC_GR;
    stl  = 1'b0;
    if (!use_s || s == 0) return;
    for (int i = 0; i < 4; i++) begin
      if (mdl[i].vld && mdl[i].dest == s) begin
        case (i)
          0: if (mdl[i].late) stl = 1'b1; else code = FWD_SRC_EX;
          1: if (mdl[i].late) stl = 1'b1; else code = FWD_SRC_MM1;
          2: code = mdl[i].late ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
          default: code = FWD_SRC_WB;
        endcase
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    int cj, ck;
    bit sj, sk;
    model_sel(int'(id_rj), id_use_rj, cj, sj);
    model_sel(int'(id_rk), id_use_rk, ck, sk);
    return id_valid && (sj || sk);
  endfunction

  task automatic verify();
    int cj, ck;
    bit sj, sk;
    #1;
    model_sel(int'(id_rj), id_use_rj, cj, sj);
    model_sel(int'(id_rk), id_use_rk, ck, sk);
    exp_q.push_back(32'(cj));
    exp_q.push_back(32'(ck));
    exp_q.push_back(32'(id_valid && (sj || sk)));
    exp_q.push_back(32'(exp_cnt));
    check("fwd_j", 32'(fwd_ctrl_j), exp_q.pop_front());
    check("fwd_k", 32'(fwd_ctrl_k), exp_q.pop_front());
    check("stall", 32'(id_stall), exp_q.pop_front());
    check("cnt", stall_cnt, exp_q.pop_front());
  endtask

  task automatic advance();
    bit stl;
    stl = model_stall();
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else if (pipe_en) begin
      for (int i = 3; i > 0; i--) mdl[i] = mdl[i-1];
      mdl[0].vld  = id_valid && !stl && id_wen && (id_dest != 0);
      mdl[0].dest = int'(id_dest);
      mdl[0].late = id_res_late;
    end
`ifdef HAZ_PERF_CNT_EN
    if (stl && pipe_en) exp_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rj, input bit uj, input int rk, input bit uk,
                        input int dest, input bit wen, input bit late);
    id_valid    = v;
    id_rj       = REG_AW'(rj);
    id_use_rj   = uj;
    id_rk       = REG_AW'(rk);
    id_use_rk   = uk;
    id_dest     = REG_AW'(dest);
    id_wen      = wen;
    id_res_late = late;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    pipe_en = 1'b1;
    flush   = 1'b0;
    repeat (4) advance();
  endtask

  initial begin
    int unsigned cnt_hold;
    resetn  = 1'b0;
    pipe_en = 1'b1;
    flush   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    verify();
    @(negedge clk);
    resetn = 1'b1;

    // back-to-back ALU dependency: distance 1 -> EX, distance 2 -> MM1
    set_id(1, 0, 0, 0, 0, 5, 1, 0); verify(); advance();
    set_id(1, 5, 1, 5, 1, 6, 1, 0); verify();
    check("t2_j_ex", 32'(fwd_ctrl_j), 32'(FWD_SRC_EX));
    check("t2_k_ex", 32'(fwd_ctrl_k), 32'(FWD_SRC_EX));
    check("t2_nostall", 32'(id_stall), 32'd0);
    advance();
    set_id(1, 5, 1, 0, 0, 7, 1, 0); verify();
    check("t2_j_mm1", 32'(fwd_ctrl_j), 32'(FWD_SRC_MM1));
    advance();

    // load-use: two stalls, then MM2_MEM, WB, GR
    drain();
    set_id(1, 0, 0, 0, 0, 4, 1, 1); verify(); advance();
    set_id(1, 4, 1, 0, 0, 8, 1, 0); verify();
    check("t3_stall1", 32'(id_stall), 32'd1);
    advance(); verify();
    check("t3_stall2", 32'(id_stall), 32'd1);
    advance(); verify();
    check("t3_go", 32'(id_stall), 32'd0);
    check("t3_mm2mem", 32'(fwd_ctrl_j), 32'(FWD_SRC_MM2_MEM));
    advance();
    set_id(1, 4, 1, 0, 0, 9, 1, 0); verify();
    check("t3_wb", 32'(fwd_ctrl_j), 32'(FWD_SRC_WB));
    advance(); verify();
    check("t3_gr", 32'(fwd_ctrl_j), 32'(FWD_SRC_GR));
    advance();

    // youngest wins (MM1 over WB); r0 never forwarded
    drain();
    set_id(1, 0, 0, 0, 0, 4, 1, 0); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); advance();
    set_id(1, 0, 0, 0, 0, 4, 1, 0); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); advance();
    set_id(1, 4, 1, 0, 1, 9, 0, 0); verify();
    check("t4_mm1", 32'(fwd_ctrl_j), 32'(FWD_SRC_MM1));
    check("t4_k_r0", 32'(fwd_ctrl_k), 32'(FWD_SRC_GR));
    advance();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); advance();
    set_id(1, 0, 1, 0, 1, 0, 0, 0); verify();
    check("t4_r0_j", 32'(fwd_ctrl_j), 32'(FWD_SRC_GR));
    check("t4_r0_k", 32'(fwd_ctrl_k), 32'(FWD_SRC_GR));
    advance();

    // backend frozen during a load-use stall
    drain();
    set_id(1, 0, 0, 0, 0, 4, 1, 1); advance();
    set_id(1, 0, 0, 4, 1, 8, 1, 0); verify();
    pipe_en  = 1'b0;
    cnt_hold = exp_cnt;
    repeat (3) begin
      advance(); verify();
      check("t5_stall_held", 32'(id_stall), 32'd1);
      check("t5_cnt_held", stall_cnt, cnt_hold);
    end
    pipe_en = 1'b1;
    advance(); advance(); verify();
    check("t5_release", 32'(id_stall), 32'd0);

    // flush beats stall
    drain();
    set_id(1, 0, 0, 0, 0, 4, 1, 1); advance();
    set_id(1, 4, 1, 4, 1, 8, 1, 0); verify();
    flush = 1'b1;
    advance();
    flush = 1'b0;
    verify();
    check("t6_nostall", 32'(id_stall), 32'd0);
    check("t6_j_gr", 32'(fwd_ctrl_j), 32'(FWD_SRC_GR));
    check("t6_k_gr", 32'(fwd_ctrl_k), 32'(FWD_SRC_GR));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      pipe_en = ($urandom_range(0, 7) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      set_id($urandom_range(0, 4) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      verify();
      advance();
    end

    // async reset with a full shadow pipeline
    pipe_en = 1'b1;
    flush   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 0, 0, 0, i + 1, 1, 0);
      advance();
    end
    set_id(1, 1, 1, 2, 1, 9, 1, 0); verify();
    check("t1_pre_j", 32'(fwd_ctrl_j), 32'(FWD_SRC_WB));
    #2;
    resetn = 1'b0;
    #1;
    check("t1_rst_j", 32'(fwd_ctrl_j), 32'(FWD_SRC_GR));
    check("t1_rst_k", 32'(fwd_ctrl_k), 32'(FWD_SRC_GR));
    check("t1_rst_stall", 32'(id_stall), 32'd0);
    check("t1_rst_cnt", stall_cnt, 32'd0);
    model_clear();
    exp_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    verify();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
